// File: rtl/my_serial_deserializer_if.sv
// Word-side handshake bundle of the serial deserializer: the received word,
// its valid/ready pair and the two per-frame status pulses.
`timescale 1ns/1ps
interface my_serial_deserializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_out;
    logic             valid;
    logic             ready;
    logic             frame_err;
    logic             overrun;

    modport master (
        output data_out,
        output valid,
        output frame_err,
        output overrun,
        input  ready
    );

    modport slave (
        input  data_out,
        input  valid,
        input  frame_err,
        input  overrun,
        output ready
    );
endinterface

// File: rtl/my_serial_deserializer.sv
// Framed serial receiver: two-flop input synchronizer, IDLE/DATA/STOP frame
// FSM with an LSB-first shift register, and a one-entry valid/ready buffer.
`timescale 1ns/1ps
module my_serial_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   serial_in,
    my_serial_deserializer_if.master bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

    state_t           state;
    state_t           state_next;
    logic             sync1;
    logic             sync2;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] shift_next;
    logic             load;
    logic             drain;
    logic             err_set;
    logic             ovr_set;

    // Input synchronizer; idle-high so reset does not look like a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= serial_in;
            sync2 <= sync1;
        end
    end

    // Frame FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Frame FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!sync2) state_next = DATA;
            DATA:    if (count == LAST) state_next = STOP;
            STOP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Frame FSM outputs: buffer load decision, status pulses, next shift value.
    always_comb begin
        drain      = bus.valid && bus.ready;
        load       = (state == STOP) && sync2 && (!bus.valid || bus.ready);
        ovr_set    = (state == STOP) && sync2 && bus.valid && !bus.ready;
        err_set    = (state == STOP) && !sync2;
        shift_next = shift >> 1;
        shift_next[WIDTH-1] = sync2;
    end

    // Bit counter and shift register; counter is re-armed every idle cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            shift <= '0;
        end else if (state == IDLE) begin
            count <= '0;
        end else if (state == DATA) begin
            shift <= shift_next;
            count <= count + CW'(1);
        end
    end

    // One-entry output buffer; a load on a draining edge replaces the word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.data_out  <= '0;
            bus.valid     <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            bus.frame_err <= err_set;
            bus.overrun   <= ovr_set;
            if (load) begin
                bus.data_out <= shift;
                bus.valid    <= 1'b1;
            end else if (drain) begin
                bus.valid    <= 1'b0;
            end
        end
    end
endmodule

// File: doc/my_serial_deserializer.md
# my_serial_deserializer

Serial-to-parallel receive stage built on a chain of D flip-flops. It takes a single-bit framed serial stream (start bit, WIDTH data bits LSB-first, stop bit, one bit per clock) and synchronizes it through a two-flop input stage. It then assembles each frame in a shift register and presents the word on a one-entry valid/ready output buffer. It sits directly downstream of a single-bit flop stage and feeds any word-wide consumer.

## Interface
Parameters:
- WIDTH, default 8, data bits per frame; legal range 1..32.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset. Asserting it clears all state immediately, independent of clk.
- serial_in  input  1  serial stream; idle level 1.
- data_out  output  WIDTH  last accepted word; bit 0 = first data bit received.
- valid  output  1  data_out holds an unconsumed word.
- ready  input  1  consumer accepts data_out at an edge where valid && ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0; the word is discarded.
- overrun  output  1  one-cycle pulse: good word completed while the buffer is full and not being drained; the new word is discarded and the old word is kept.

## Operation
- Reset values:
  - sync1 = sync2 = 1.
  - FSM in IDLE; bit counter = 0; shift register = 0.
  - data_out = 0; valid = 0; frame_err = 0; overrun = 0.
- Synchronizer: sync1 <= serial_in, then sync2 <= sync1. The FSM sees only sync2.
- FSM states:
  - IDLE: sync2 == 0 → DATA, counter = 0. Otherwise stay in IDLE.
  - DATA: each edge, shift = {sync2, shift[WIDTH-1:1]} and counter++. On the edge where counter == WIDTH-1 → STOP.
  - STOP, sync2 == 1 (good frame): load the shift register into data_out and set valid = 1 if valid == 0 or (valid && ready) this edge. Otherwise pulse overrun. Then → IDLE.
  - STOP, sync2 == 0: pulse frame_err, do not load data_out, → IDLE.
- Output buffer:
  - Set valid && ready with no new load → valid = 0, data_out retained.
  - Set valid && ready with a load on the same edge → valid stays 1 and data_out takes the new word.
  - data_out must not change while valid == 1 and ready == 0.
- frame_err and overrun are registered and high for exactly one cycle. They never assert together.
- Back-to-back frames: a start bit immediately after the stop bit, with no idle bit, is accepted. IDLE sees it on the cycle after STOP.
- Counter width is clog2(WIDTH), minimum 1. For WIDTH == 1, DATA lasts a single edge.

## Timing
- Bit sampling:
  - Start bit sampled into sync1 at edge e0.
  - Data bit i sampled at edge e0+1+i.
  - Stop bit sampled at edge e0+WIDTH+1.
- valid rises (or frame_err/overrun pulses) after edge e0+WIDTH+3. For WIDTH=8, that is 11 edges after the start bit is sampled.
- Minimum frame period: WIDTH+2 cycles. Sustained throughput is one word per WIDTH+2 cycles with ready held high.
- ready is a combinational input sampled at the edge; there is no combinational path from ready to valid or data_out.
- Reset mid-frame or with valid=1: outputs return to reset values immediately. The partial frame is lost. The first frame is recognized only after reset_n deasserts and a fresh 1→0 start edge reaches sync2.

## Test plan
- Single frame, WIDTH=8, ready=1: idle 1s, then bits 0,1,0,1,0,0,1,0,1,1 (0xA5 LSB-first) → valid high 11 edges after the start sample, data_out=8'hA5, valid drops the next edge; frame_err=overrun=0 throughout.
- Framing error: same frame with stop bit 0 → frame_err pulses for one cycle at edge e0+11; valid stays 0; data_out unchanged (0 after reset). A following good 0x3C frame is received correctly.
- Backpressure and overrun: ready=0, send 0x11 then 0x22 back-to-back → valid=1 with data_out=8'h11; overrun pulses once when 0x22 completes; data_out stays 8'h11 until ready=1, then valid falls.
- Simultaneous drain and load: valid=1 with 0x11; ready asserted exactly on the edge 0x22 completes → valid stays 1, data_out=8'h22, overrun=0.
- Back-to-back throughput: send 0x01, 0x80, 0xFF, 0x00 with no idle bits, ready=1 → four valid pulses spaced 10 cycles apart with the correct values, no errors.
- Async reset: assert reset_n=0 mid-DATA while not aligned to clk → all outputs go to 0 immediately. After release, a new 0x5A frame is received correctly, with no residue from the aborted frame.
